// File: rtl/loss_accuracy_unit.sv
// rtl/loss_accuracy_unit.sv - output error, squared-error loss, argmax and batch counters after the FC layer
module loss_accuracy_unit #(
    parameter int DATA_W      = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_CLASSES = 10,
    parameter int BATCH_SIZE  = 32,
    parameter int LOSS_W      = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [3:0]               i_label_idx,
    input  logic                     i_fc_valid,
    output logic                     o_fc_ready,
    input  logic signed [DATA_W-1:0] i_fc_data,
    input  logic [3:0]               i_fc_addr,
    output logic                     o_err_valid,
    input  logic                     i_err_ready,
    output logic [DATA_W-1:0]        o_err_data,
    output logic [3:0]               o_err_addr,
    output logic                     o_sample_done,
    output logic [3:0]               o_pred_class,
    output logic                     o_pred_correct,
    output logic                     o_batch_done,
    output logic [LOSS_W-1:0]        o_batch_loss,
    output logic [7:0]               o_batch_correct,
    output logic                     o_protocol_err
);

    localparam int CNT_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam logic signed [DATA_W:0] TARGET_ONE = (DATA_W+1)'(1) << FRAC_BITS;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [3:0]                r_label;
    logic [3:0]                r_idx;
    logic [LOSS_W-1:0]         r_sample_loss;
    logic signed [DATA_W-1:0]  r_max;
    logic [3:0]                r_max_idx;
    logic                      r_err_valid;
    logic [DATA_W-1:0]         r_err_data;
    logic [3:0]                r_err_addr;
    logic                      r_sample_done;
    logic [3:0]                r_pred_class;
    logic                      r_pred_correct;
    logic                      r_batch_done;
    logic [LOSS_W-1:0]         r_batch_loss;
    logic [7:0]                r_batch_correct;
    logic [LOSS_W-1:0]         r_batch_loss_acc;
    logic [7:0]                r_correct_acc;
    logic [CNT_W-1:0]          r_sample_cnt;
    logic                      r_protocol_err;

    logic                      w_fc_ready;
    logic                      w_accept;
    logic                      w_last;
    logic signed [DATA_W:0]    w_target;
    logic signed [DATA_W:0]    w_diff_wide;
    logic [DATA_W-1:0]         w_diff;
    logic [DATA_W-1:0]         w_mag;
    logic [2*DATA_W-1:0]       w_sq;
    logic [2*DATA_W-1:0]       w_sq_shift;
    logic [LOSS_W:0]           w_loss_sum;
    logic [LOSS_W-1:0]         w_loss_sat;
    logic                      w_new_max;
    logic                      w_correct;
    logic [LOSS_W:0]           w_batch_sum;
    logic [LOSS_W-1:0]         w_batch_sat;
    logic [7:0]                w_correct_sum;

    // The single error slot may accept a new element in the same cycle it is drained.
    assign w_fc_ready = (r_state == S_ACCUM) && (!r_err_valid || i_err_ready);
    assign w_accept   = i_fc_valid && w_fc_ready;
    assign w_last     = (r_idx == 4'(NUM_CLASSES - 1));

    assign w_target    = (r_idx == r_label) ? TARGET_ONE : '0;
    assign w_diff_wide = {i_fc_data[DATA_W-1], i_fc_data} - w_target;

    // Saturate the 17-bit difference, then square its magnitude; -32768 squares as +32768.
    always_comb begin
        w_diff = w_diff_wide[DATA_W-1:0];
        if (w_diff_wide[DATA_W] ^ w_diff_wide[DATA_W-1]) begin
            w_diff = w_diff_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        w_mag       = w_diff[DATA_W-1] ? (~w_diff + 1'b1) : w_diff;
        w_sq        = w_mag * w_mag;
        w_sq_shift  = w_sq >> FRAC_BITS;
        w_loss_sum  = {1'b0, r_sample_loss} + (LOSS_W+1)'(w_sq_shift);
        w_loss_sat  = w_loss_sum[LOSS_W] ? '1 : w_loss_sum[LOSS_W-1:0];
        w_new_max   = (r_idx == 4'd0) || (i_fc_data > r_max);
        w_correct   = (r_max_idx == r_label);
        w_batch_sum = {1'b0, r_batch_loss_acc} + {1'b0, r_sample_loss};
        w_batch_sat = w_batch_sum[LOSS_W] ? '1 : w_batch_sum[LOSS_W-1:0];
        w_correct_sum = r_correct_acc + {7'd0, w_correct};
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a sample ends when the last class index is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_next = S_ACCUM;
            S_ACCUM:  if (w_accept && w_last) w_state_next = S_REPORT;
            S_REPORT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath: error slot, per-sample accumulation and per-batch counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_label          <= '0;
            r_idx            <= '0;
            r_sample_loss    <= '0;
            r_max            <= '0;
            r_max_idx        <= '0;
            r_err_valid      <= 1'b0;
            r_err_data       <= '0;
            r_err_addr       <= '0;
            r_sample_done    <= 1'b0;
            r_pred_class     <= '0;
            r_pred_correct   <= 1'b0;
            r_batch_done     <= 1'b0;
            r_batch_loss     <= '0;
            r_batch_correct  <= '0;
            r_batch_loss_acc <= '0;
            r_correct_acc    <= '0;
            r_sample_cnt     <= '0;
            r_protocol_err   <= 1'b0;
        end else begin
            r_sample_done <= 1'b0;
            r_batch_done  <= 1'b0;

            if (w_accept) begin
                r_err_valid <= 1'b1;
                r_err_data  <= w_diff;
                r_err_addr  <= r_idx;
            end else if (i_err_ready) begin
                r_err_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_label       <= i_label_idx;
                        r_idx         <= '0;
                        r_sample_loss <= '0;
                        r_max         <= '0;
                        r_max_idx     <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_sample_loss <= w_loss_sat;
                        if (w_new_max) begin
                            r_max     <= i_fc_data;
                            r_max_idx <= r_idx;
                        end
                        if (i_fc_addr != r_idx) begin
                            r_protocol_err <= 1'b1;
                        end
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_REPORT: begin
                    r_sample_done  <= 1'b1;
                    r_pred_class   <= r_max_idx;
                    r_pred_correct <= w_correct;
                    if (r_sample_cnt == CNT_W'(BATCH_SIZE - 1)) begin
                        r_batch_done     <= 1'b1;
                        r_batch_loss     <= w_batch_sat;
                        r_batch_correct  <= w_correct_sum;
                        r_batch_loss_acc <= '0;
                        r_correct_acc    <= '0;
                        r_sample_cnt     <= '0;
                    end else begin
                        r_batch_loss_acc <= w_batch_sat;
                        r_correct_acc    <= w_correct_sum;
                        r_sample_cnt     <= r_sample_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_fc_ready      = w_fc_ready;
    assign o_err_valid     = r_err_valid;
    assign o_err_data      = r_err_data;
    assign o_err_addr      = r_err_addr;
    assign o_sample_done   = r_sample_done;
    assign o_pred_class    = r_pred_class;
    assign o_pred_correct  = r_pred_correct;
    assign o_batch_done    = r_batch_done;
    assign o_batch_loss    = r_batch_loss;
    assign o_batch_correct = r_batch_correct;
    assign o_protocol_err  = r_protocol_err;

endmodule
